// File: rtl/fft_bin_streamer_if.sv
// -----------------------------------------------------------------------------
// fft_bin_streamer_if
// Output stream of the FFT bin serializer: one complex bin per transfer.
//
// Handshake: a beat transfers on a clock edge where out_valid and out_ready are
// both 1. The master holds out_valid and all payload fields stable until that
// transfer happens. out_valid never depends on out_ready, and out_ready may be
// high while out_valid is low with no effect.
//
// Signals:
//   out_valid  master->slave  current beat is valid
//   out_ready  slave->master  downstream accepts the beat
//   out_Re     master->slave  real part of the current bin
//   out_Im     master->slave  imaginary part of the current bin
//   out_index  master->slave  bin number of the current beat
//   out_last   master->slave  current beat is the final bin of the frame
// -----------------------------------------------------------------------------
interface fft_bin_streamer_if #(
  parameter int S_WIDTH     = 16,
  parameter int LOG_2_WIDTH = 6
);
  logic                   out_valid;
  logic                   out_ready;
  logic [S_WIDTH-1:0]     out_Re;
  logic [S_WIDTH-1:0]     out_Im;
  logic [LOG_2_WIDTH-1:0] out_index;
  logic                   out_last;

  modport master (
    output out_valid, out_Re, out_Im, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_Re, out_Im, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_bin_streamer.sv
// -----------------------------------------------------------------------------
// fft_bin_streamer
// Snapshots a full frame of complex FFT bins on a one-cycle fft_done pulse and
// streams them out in natural bin order, one bin per transfer. All state is
// updated on the falling clock edge to line up with the butterfly array.
//
// Ports:
//   clk        clock (state changes on the falling edge)
//   rst        asynchronous active-low reset
//   fft_done   single-cycle pulse: in_Re/in_Im hold a completed frame
//   in_Re      D_WIDTH real parts, index = bin number
//   in_Im      D_WIDTH imaginary parts
//   out_bus    output stream (valid/ready, bin payload, index, last)
//   busy       a frame is buffered or draining
//   overrun    sticky: an fft_done was dropped because a frame was draining
//   state_dbg  current FSM state (0 = IDLE, 1 = STREAM)
// -----------------------------------------------------------------------------
module fft_bin_streamer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fft_done,
  input  logic [S_WIDTH-1:0]  in_Re [D_WIDTH],
  input  logic [S_WIDTH-1:0]  in_Im [D_WIDTH],
  fft_bin_streamer_if.master  out_bus,
  output logic                busy,
  output logic                overrun,
  output logic                state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [LOG_2_WIDTH-1:0] index_q, index_d;
  logic                   load;
  logic                   set_ovr;
  logic                   xfer;
  logic                   at_last;

  logic [S_WIDTH-1:0] buf_re [D_WIDTH];
  logic [S_WIDTH-1:0] buf_im [D_WIDTH];

  assign xfer    = (state_q == STREAM) && out_bus.out_ready;
  assign at_last = (index_q == LAST_IDX);

  // Next-state logic. A capture in STREAM is only legal on the edge that also
  // retires the final bin; that is what lets frames run back to back with no
  // bubble. Any other fft_done while draining is dropped and flagged.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    load    = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft_done) begin
          load    = 1'b1;
          index_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          index_d = '0;
          if (fft_done) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + LOG_2_WIDTH'(1);
          end
          if (fft_done) begin
            set_ovr = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      index_q <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      overrun <= overrun | set_ovr;
    end
  end

  // Frame buffer: written only on a capture edge, so the inputs are free to
  // change as soon as that edge has passed.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re[i] <= in_Re[i];
        buf_im[i] <= in_Im[i];
      end
    end
  end

  // Output mux straight from registered state, so outputs only move after an
  // edge (or immediately on asynchronous reset). The index returns to 0 on the
  // way back to IDLE, so the idle bus shows index 0.
  assign out_bus.out_valid = (state_q == STREAM);
  assign out_bus.out_index = index_q;
  assign out_bus.out_Re    = buf_re[index_q];
  assign out_bus.out_Im    = buf_im[index_q];
  assign out_bus.out_last  = (state_q == STREAM) && at_last;
  assign busy              = (state_q == STREAM);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// -----------------------------------------------------------------------------
// tb_fft_bin_streamer
// Directed sequence with randomized frames and backpressure. The reference is a
// queue of expected beats: a capture pushes the whole frame, a transfer pops
// the head. The DUT acts on the falling edge, so inputs are driven and outputs
// are sampled on the rising edge.
// -----------------------------------------------------------------------------
module tb_fft_bin_streamer;

  localparam int D_WIDTH     = 64;
  localparam int LOG_2_WIDTH = 6;
  localparam int S_WIDTH     = 16;
  localparam int W           = 2 * S_WIDTH + LOG_2_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic               fft_done;
  logic [S_WIDTH-1:0] in_Re [D_WIDTH];
  logic [S_WIDTH-1:0] in_Im [D_WIDTH];
  logic               busy;
  logic               overrun;
  logic               state_dbg;

  fft_bin_streamer_if #(.S_WIDTH(S_WIDTH), .LOG_2_WIDTH(LOG_2_WIDTH)) bus ();

  fft_bin_streamer #(
    .D_WIDTH(D_WIDTH), .LOG_2_WIDTH(LOG_2_WIDTH), .S_WIDTH(S_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .in_Re(in_Re), .in_Im(in_Im),
    .out_bus(bus.master),
    .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]       exp_q[$];   // {re, im, index} of beats still to come
  logic               m_ovr;
  logic [S_WIDTH-1:0] idle_re;    // bin 0 of the most recent capture
  logic [S_WIDTH-1:0] idle_im;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("valid",  32'(bus.out_valid), 32'd1);
      chk("busy",   32'(busy),          32'd1);
      chk("re",     32'(bus.out_Re),    32'(e[W-1 -: S_WIDTH]));
      chk("im",     32'(bus.out_Im),    32'(e[LOG_2_WIDTH +: S_WIDTH]));
      chk("index",  32'(bus.out_index), 32'(e[LOG_2_WIDTH-1:0]));
      chk("last",   32'(bus.out_last),  32'(e[LOG_2_WIDTH-1:0] == 6'd63));
    end else begin
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_busy",  32'(busy),          32'd0);
      chk("idle_index", 32'(bus.out_index), 32'd0);
      chk("idle_re",    32'(bus.out_Re),    32'(idle_re));
      chk("idle_im",    32'(bus.out_Im),    32'(idle_im));
      chk("idle_last",  32'(bus.out_last),  32'd0);
    end
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovr   = 1'b0;
    idle_re = '0;
    idle_im = '0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs, advance the reference, let the falling edge act,
  // then check on the following rising edge.
  task automatic cycle(input bit done, input bit rdy);
    int  n;
    bit  final_beat;
    fft_done      = done;
    bus.out_ready = rdy;
    if (rst) begin
      n          = exp_q.size();
      final_beat = (n == 1) && rdy;
      if (n > 0 && rdy) void'(exp_q.pop_front());
      if (done) begin
        if (n == 0 || final_beat) begin
          for (int i = 0; i < D_WIDTH; i++)
            exp_q.push_back({in_Re[i], in_Im[i], LOG_2_WIDTH'(i)});
          idle_re = in_Re[0];
          idle_im = in_Im[0];
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    @(negedge clk);
    @(posedge clk);
    fft_done = 1'b0;
    check_outputs();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < D_WIDTH; i++) begin
      in_Re[i] = S_WIDTH'(i);
      in_Im[i] = 16'hFFFF - S_WIDTH'(i);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < D_WIDTH; i++) begin
      in_Re[i] = S_WIDTH'($urandom);
      in_Im[i] = S_WIDTH'($urandom);
    end
  endtask

  task automatic set_const(input logic [S_WIDTH-1:0] v);
    for (int i = 0; i < D_WIDTH; i++) begin
      in_Re[i] = v;
      in_Im[i] = v;
    end
  endtask

  // Run with random backpressure until the reference has no beats left.
  task automatic drain_random();
    for (int k = 0; k < 1000 && exp_q.size() > 0; k++)
      cycle(1'b0, 1'($urandom_range(0, 1)));
    chk("drain_bound", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    fft_done      = 1'b0;
    bus.out_ready = 1'b0;
    set_const('0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    check_outputs();
    rst = 1'b1;

    // Idle with out_ready high: nothing happens
    repeat (10) cycle(1'b0, 1'b1);

    // Full-throughput ramp frame: bins 0..63 on consecutive cycles
    set_ramp();
    cycle(1'b1, 1'b1);
    set_random();
    for (int i = 0; i < D_WIDTH; i++) cycle(1'b0, 1'b1);
    chk("ramp_done_busy", 32'(busy), 32'd0);
    repeat (3) cycle(1'b0, 1'b1);

    // Backpressure: ready alternating 1,0 -> 128 cycles to drain
    set_random();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 2 * D_WIDTH; i++) cycle(1'b0, 1'(i % 2 == 0));
    chk("bp_done_busy", 32'(busy), 32'd0);
    repeat (2) cycle(1'b0, 1'b0);

    // Back-to-back: frame B captured on the index-63 transfer of frame A
    set_random();
    cycle(1'b1, 1'b1);
    set_random();
    for (int i = 0; i < D_WIDTH - 1; i++) cycle(1'b0, 1'b1);
    chk("b2b_at_last", 32'(bus.out_last), 32'd1);
    set_random();
    cycle(1'b1, 1'b1);
    chk("b2b_no_gap", 32'(bus.out_valid), 32'd1);
    drain_random();

    // Overrun while at index 10 with inputs changed to 5A5A
    set_random();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    set_const(16'h5A5A);
    cycle(1'b1, 1'b1);
    drain_random();
    repeat (4) cycle(1'b0, 1'($urandom_range(0, 1)));

    // A random frame with random backpressure
    set_random();
    cycle(1'b1, 1'($urandom_range(0, 1)));
    set_random();
    drain_random();

    // Asynchronous reset while streaming at index 20
    set_random();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_index",   32'(bus.out_index), 32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_re",      32'(bus.out_Re),    32'd0);
    repeat (2) cycle(1'b0, 1'b1);
    rst = 1'b1;
    repeat (5) cycle(1'b0, 1'b1);

    // A fresh frame after reset
    set_random();
    cycle(1'b1, 1'b0);
    drain_random();
    repeat (2) cycle(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
